// File: rtl/writeback_queue.sv
// writeback_queue
//   Write-side initiator for the 32x32 register file. Collects register-write
//   requests from the ALU and load paths, queues them in a circular buffer,
//   and drains one entry per clock onto the RF write port. Queued entries are
//   also searched so the decode-stage read ports can forward pending writes.
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   alu_valid/reg/data       ALU write request (younger of the two sources)
//   mem_valid/reg/data       load write request (older of the two sources)
//   ready                    queue has room for two pushes this cycle
//   RegWrite/WriteRegister/
//   WriteData                RF write port, driven directly from the head entry
//   ReadRegister1/2          decode read indices, snooped for forwarding
//   fwd1_hit/fwd1_data,
//   fwd2_hit/fwd2_data       youngest queued value for each read index
//   count                    number of occupied entries
module writeback_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [ADDR_W-1:0]        alu_reg,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     mem_valid,
  input  logic [ADDR_W-1:0]        mem_reg,
  input  logic [DATA_W-1:0]        mem_data,
  output logic                     ready,
  output logic                     RegWrite,
  output logic [ADDR_W-1:0]        WriteRegister,
  output logic [DATA_W-1:0]        WriteData,
  input  logic [ADDR_W-1:0]        ReadRegister1,
  input  logic [ADDR_W-1:0]        ReadRegister2,
  output logic                     fwd1_hit,
  output logic [DATA_W-1:0]        fwd1_data,
  output logic                     fwd2_hit,
  output logic [DATA_W-1:0]        fwd2_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  // Entry storage; contents are don't-care after reset, so no reset here.
  logic [ADDR_W-1:0] wreg_q  [DEPTH];
  logic [DATA_W-1:0] wdata_q [DEPTH];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              mem_push;
  logic              alu_push;
  logic [1:0]        n_push;
  logic              pop;
  logic [PTR_W-1:0]  alu_idx;

  // ready looks only at the registered count so it never forms a loop with
  // the request sources.
  assign ready = (count_q <= CNT_W'(DEPTH - 2));

  // Writes to $0 are dropped here and never take an entry.
  assign mem_push = ready && mem_valid && (mem_reg != '0);
  assign alu_push = ready && alu_valid && (alu_reg != '0);
  assign n_push   = {1'b0, mem_push} + {1'b0, alu_push};
  assign pop      = (count_q != '0);

  // mem is the older instruction, so it takes the tail slot; alu follows it
  // (or takes tail itself when mem does not push).
  assign alu_idx  = tail_q + PTR_W'(mem_push);

  always_comb begin
    head_d  = head_q + PTR_W'(pop);
    tail_d  = tail_q + PTR_W'(n_push);
    count_d = count_q + CNT_W'(n_push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_push) begin
      wreg_q[tail_q]  <= mem_reg;
      wdata_q[tail_q] <= mem_data;
    end
    if (alu_push) begin
      wreg_q[alu_idx]  <= alu_reg;
      wdata_q[alu_idx] <= alu_data;
    end
  end

  // Head entry drives the RF port directly; the RF captures it on the same
  // edge that pops it.
  assign RegWrite      = pop;
  assign WriteRegister = wreg_q[head_q];
  assign WriteData     = wdata_q[head_q];
  assign count         = count_q;

  // Walk occupied entries oldest to youngest; later matches overwrite earlier
  // ones, so the result is the youngest match. Data stays zero on a miss.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx       = '0;
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) begin
        if ((ReadRegister1 != '0) && (wreg_q[idx] == ReadRegister1)) begin
          fwd1_hit  = 1'b1;
          fwd1_data = wdata_q[idx];
        end
        if ((ReadRegister2 != '0) && (wreg_q[idx] == ReadRegister2)) begin
          fwd2_hit  = 1'b1;
          fwd2_data = wdata_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
module tb_writeback_queue;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] r;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   accepted;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    alu_valid, mem_valid;
  logic [ADDR_W-1:0]       alu_reg, mem_reg;
  logic [DATA_W-1:0]       alu_data, mem_data;
  logic                    ready, RegWrite;
  logic [ADDR_W-1:0]       WriteRegister;
  logic [DATA_W-1:0]       WriteData;
  logic [ADDR_W-1:0]       ReadRegister1, ReadRegister2;
  logic                    fwd1_hit, fwd2_hit;
  logic [DATA_W-1:0]       fwd1_data, fwd2_data;
  logic [$clog2(DEPTH):0]  count;

  always #5 clk = ~clk;

  writeback_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data),
    .ready(ready),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
    .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
    .count(count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Youngest queued value for a read index; oldest-first walk, last match wins.
  function automatic void model_fwd(input logic [ADDR_W-1:0] rr,
                                    output logic hit, output logic [DATA_W-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (rr != '0)
      foreach (sb[i])
        if (sb[i].r == rr) begin
          hit = 1'b1;
          d   = sb[i].d;
        end
  endfunction

  task automatic clear_req();
    alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
    mem_valid = 1'b0; mem_reg = '0; mem_data = '0;
  endtask

  // Entered just after a rising edge with inputs already driven; checks at the
  // falling edge, then updates the scoreboard for the next rising edge.
  task automatic step();
    logic             h;
    logic [DATA_W-1:0] fd;
    int               sz;
    @(negedge clk);
    sz = sb.size();
    check_eq("RegWrite", RegWrite, sz != 0);
    check_eq("count", 32'(count), sz);
    check_eq("ready", ready, sz <= int'(DEPTH) - 2);
    model_fwd(ReadRegister1, h, fd);
    check_eq("fwd1_hit", fwd1_hit, h);
    check_eq("fwd1_data", fwd1_data, fd);
    model_fwd(ReadRegister2, h, fd);
    check_eq("fwd2_hit", fwd2_hit, h);
    check_eq("fwd2_data", fwd2_data, fd);
    if (sz != 0) begin
      check_eq("WriteRegister", 32'(WriteRegister), 32'(sb[0].r));
      check_eq("WriteData", WriteData, sb[0].d);
      sb.delete(0);
    end
    accepted = (sz <= int'(DEPTH) - 2);
    if (accepted) begin
      if (mem_valid && mem_reg != '0) sb.push_back({mem_reg, mem_data});
      if (alu_valid && alu_reg != '0) sb.push_back({alu_reg, alu_data});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    int tries;
    rst = 1'b1;
    clear_req();
    ReadRegister1 = '0;
    ReadRegister2 = '0;

    // 1. reset then idle
    #3;
    check_eq("rst_RegWrite", RegWrite, 1'b0);
    check_eq("rst_count", 32'(count), 0);
    check_eq("rst_ready", ready, 1'b1);
    check_eq("rst_fwd1_hit", fwd1_hit, 1'b0);
    check_eq("rst_fwd2_hit", fwd2_hit, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(); step();

    // 2. single write
    alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'h0000_1234;
    step();
    clear_req();
    step();
    step();

    // 3. dual push, mem drains before alu
    mem_valid = 1'b1; mem_reg = 5'd8; mem_data = 32'hAAAA_0000;
    alu_valid = 1'b1; alu_reg = 5'd9; alu_data = 32'h0000_BBBB;
    step();
    clear_req();
    step(); step(); step();

    // 4. $0 dropped, read index 0 never forwards
    alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'hFFFF_FFFF;
    mem_valid = 1'b1; mem_reg = 5'd3; mem_data = 32'h0000_0007;
    ReadRegister1 = 5'd0; ReadRegister2 = 5'd3;
    step();
    clear_req();
    step(); step();

    // 5. youngest match forwarded while duplicates drain
    ReadRegister1 = 5'd0; ReadRegister2 = 5'd4;
    mem_valid = 1'b1; mem_reg = 5'd4; mem_data = 32'h0000_0011;
    alu_valid = 1'b1; alu_reg = 5'd4; alu_data = 32'h0000_0022;
    step();
    clear_req();
    @(negedge clk);
    check_eq("fwd_young_two", fwd2_data, 32'h0000_0022);
    @(posedge clk); #1;
    sb.delete(0);
    @(negedge clk);
    check_eq("fwd_young_one", fwd2_data, 32'h0000_0022);
    @(posedge clk); #1;
    sb.delete(0);
    step();

    // 6. full and stall with held requests, then reset mid-drain
    ReadRegister1 = 5'd11; ReadRegister2 = 5'd12;
    k = 0;
    for (int n = 0; n < 12; n++) begin
      mem_valid = 1'b1; mem_reg = ADDR_W'(1 + (2 * k) % 30);
      mem_data = 32'hC000_0000 + 32'(k);
      alu_valid = 1'b1; alu_reg = ADDR_W'(2 + (2 * k) % 30);
      alu_data = 32'hD000_0000 + 32'(k);
      step();
      if (accepted) k++;
    end
    tries = 0;
    while (sb.size() != 3 && tries < 8) begin
      mem_reg = ADDR_W'(1 + (2 * k) % 30); mem_data = 32'hC000_0000 + 32'(k);
      alu_reg = ADDR_W'(2 + (2 * k) % 30); alu_data = 32'hD000_0000 + 32'(k);
      step();
      if (accepted) k++;
      tries++;
    end
    clear_req();
    check_eq("full_count", 32'(count), 3);
    check_eq("full_ready", ready, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_eq("midrst_RegWrite", RegWrite, 1'b0);
    check_eq("midrst_count", 32'(count), 0);
    check_eq("midrst_ready", ready, 1'b1);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    step(); step(); step();

    // random traffic over a small register set for duplicates and forwarding
    for (int n = 0; n < 200; n++) begin
      mem_valid = 1'($urandom_range(0, 1));
      mem_reg   = ADDR_W'($urandom_range(0, 7));
      mem_data  = $urandom;
      alu_valid = 1'($urandom_range(0, 1));
      alu_reg   = ADDR_W'($urandom_range(0, 7));
      alu_data  = $urandom;
      ReadRegister1 = ADDR_W'($urandom_range(0, 7));
      ReadRegister2 = ADDR_W'($urandom_range(0, 7));
      step();
    end
    clear_req();
    for (int n = 0; n < int'(DEPTH) + 2; n++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
